// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame buffer write path: channel widths,
// default geometry and the write-side FSM state type.
package frame_buf_pkg;

    localparam int RGB444_CH_W = 4;
    localparam int RGB333_CH_W = 3;

    localparam int DEF_H_SIZE = 640;
    localparam int DEF_V_SIZE = 480;
    localparam int DEF_ADDR_W = 19;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/frame_quant_ch.sv
// Single-channel 4->3 bit quantizer; the dither bit is added before the
// bit drop and the result saturates at full scale instead of wrapping.
module frame_quant_ch
    import frame_buf_pkg::*;
(
    input  logic [RGB444_CH_W-1:0] c4,
    input  logic                   dither,
    output logic [RGB333_CH_W-1:0] c3
);

    logic [RGB444_CH_W:0] sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum = {1'b0, c4} + {{RGB444_CH_W{1'b0}}, dither};
        c3  = sum[RGB444_CH_W-1:1];
        if (sum[RGB444_CH_W]) begin
            c3 = '1;
        end
    end

endmodule

// File: rtl/frame_color_quantizer.sv
// Streams RGB444 pixels into video RAM as RGB333 words, one full frame per
// start command, with optional 2x2 ordered dither.
module frame_color_quantizer
    import frame_buf_pkg::*;
#(
    parameter int H_SIZE    = DEF_H_SIZE,
    parameter int V_SIZE    = DEF_V_SIZE,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DITHER_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int XW = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
    localparam int YW = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_SIZE - 1);

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              last_px;
    logic              dither;
    logic [8:0]        q_color;

    // in_ready depends on the state register alone so the master never sees a combinational loop.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign last_px  = (x == X_LAST) && (y == Y_LAST);
    assign dither   = (DITHER_EN != 0) && (x[0] ^ y[0]);

    frame_quant_ch u_quant_r (.c4(in_color[11:8]), .dither(dither), .c3(q_color[8:6]));
    frame_quant_ch u_quant_g (.c4(in_color[7:4]),  .dither(dither), .c3(q_color[5:3]));
    frame_quant_ch u_quant_b (.c4(in_color[3:0]),  .dither(dither), .c3(q_color[2:0]));

    // NOTE: registered state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
        end else begin
            wr_en      <= accept;
            frame_done <= accept && last_px;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= q_color;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= '0;
                        y     <= '0;
                        addr  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_px) begin
                            x     <= '0;
                            y     <= '0;
                            addr  <= '0;
                            state <= IDLE;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                            if (x == X_LAST) begin
                                x <= '0;
                                y <= y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
